// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32 controller: opcodes, FSM states,
// ALU operation codes and datapath mux selects.
package ctrl_pkg;

  localparam int ALU_Control_Signal = 3;
  localparam int Op_Width           = 7;

  localparam logic [Op_Width-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [Op_Width-1:0] OP_STORE  = 7'b0100011;
  localparam logic [Op_Width-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [Op_Width-1:0] OP_ITYPE  = 7'b0010011;
  localparam logic [Op_Width-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [Op_Width-1:0] OP_JAL    = 7'b1101111;

  // Code 3'b011 is reserved and never produced.
  localparam logic [ALU_Control_Signal-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_Control_Signal-1:0] ALU_SLL = 3'b001;
  localparam logic [ALU_Control_Signal-1:0] ALU_SUB = 3'b010;
  localparam logic [ALU_Control_Signal-1:0] ALU_XOR = 3'b100;
  localparam logic [ALU_Control_Signal-1:0] ALU_SRL = 3'b101;
  localparam logic [ALU_Control_Signal-1:0] ALU_OR  = 3'b110;
  localparam logic [ALU_Control_Signal-1:0] ALU_AND = 3'b111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL
  } state_t;

endpackage

// File: rtl/multicycle_controller_if.sv
// Bundle between the controller (master) and the datapath/cache side (slave):
// instruction fields and flags in, mux selects and enables out.
interface multicycle_controller_if;
  import ctrl_pkg::*;

  logic [Op_Width-1:0]           Op;
  logic [2:0]                    Funct3;
  logic                          Funct7b5;
  logic                          Zero;
  logic                          Sign;
  logic                          MemReady;
  logic                          PCWrite;
  logic                          AdrSrc;
  logic                          MemRead;
  logic                          MemWrite;
  logic                          IRWrite;
  logic                          RegWrite;
  logic [1:0]                    ResultSrc;
  logic [1:0]                    ALUSrcA;
  logic [1:0]                    ALUSrcB;
  logic [1:0]                    ImmSrc;
  logic [ALU_Control_Signal-1:0] ALUControl;
  logic                          Illegal;

  modport master (
    input  Op, Funct3, Funct7b5, Zero, Sign, MemReady,
    output PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  );

  modport slave (
    output Op, Funct3, Funct7b5, Zero, Sign, MemReady,
    input  PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, Illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp/Funct3/Funct7b5/Op[5] to an ALU code
// and flags the arithmetic instructions this core does not implement.
module alu_decoder
  import ctrl_pkg::*;
(
  input  alu_op_t                       alu_op,
  input  logic [2:0]                    funct3,
  input  logic                          funct7b5,
  input  logic                          op_b5,
  output logic [ALU_Control_Signal-1:0] alu_control,
  output logic                          illegal
);

  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      default: begin
        // Funct7b5 means sub only for R-type; for I-type it is an immediate bit.
        case (funct3)
          3'b000:  alu_control = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control = ALU_SLL;
          3'b100:  alu_control = ALU_XOR;
          3'b101: begin
            alu_control = ALU_SRL;
            illegal     = funct7b5;
          end
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32 control FSM with Moore-decoded datapath controls.
// Define BRANCH_EXT_EN to add bne/blt/bge; otherwise only beq is supported.
module multicycle_controller
  import ctrl_pkg::*;
(
  input logic                     CLK,
  input logic                     RST,
  multicycle_controller_if.master bus
);

  state_t                        state_q, state_d;
  alu_op_t                       alu_op;
  logic [ALU_Control_Signal-1:0] dec_control;
  logic                          dec_illegal;
  logic                          pc_update, branch, taken, branch_illegal;

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (bus.Funct3),
    .funct7b5    (bus.Funct7b5),
    .op_b5       (bus.Op[5]),
    .alu_control (dec_control),
    .illegal     (dec_illegal)
  );

  always_comb begin
    case (state_q)
      S_EXECR, S_EXECI: alu_op = ALUOP_FUNCT;
      S_BRANCH:         alu_op = ALUOP_SUB;
      default:          alu_op = ALUOP_ADD;
    endcase
  end

`ifdef BRANCH_EXT_EN
  // Signed compares look at Sign only; overflow is deliberately ignored.
  always_comb begin
    taken          = 1'b0;
    branch_illegal = 1'b0;
    case (bus.Funct3)
      3'b000:  taken = bus.Zero;
      3'b001:  taken = !bus.Zero;
      3'b100:  taken = bus.Sign;
      3'b101:  taken = !bus.Sign;
      default: branch_illegal = 1'b1;
    endcase
  end
`else
  logic sign_unused;
  assign sign_unused = bus.Sign;

  always_comb begin
    taken          = 1'b0;
    branch_illegal = 1'b0;
    if (bus.Funct3 == 3'b000) taken = bus.Zero;
    else                      branch_illegal = 1'b1;
  end
`endif

  always_comb begin
    state_d        = state_q;
    pc_update      = 1'b0;
    branch         = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemRead    = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = RES_ALUOUT;
    bus.ALUSrcA    = SRCA_PC;
    bus.ALUSrcB    = SRCB_RD2;
    bus.ImmSrc     = IMM_I;
    bus.Illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.MemRead   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        if (bus.MemReady) begin
          bus.IRWrite = 1'b1;
          pc_update   = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = IMM_B;
        case (bus.Op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default: begin
            bus.Illegal = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = SRCB_IMM;
        bus.ImmSrc  = bus.Op[5] ? IMM_S : IMM_I;
        state_d     = bus.Op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.AdrSrc  = 1'b1;
        bus.MemRead = 1'b1;
        if (bus.MemReady) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.ResultSrc = RES_MEMDATA;
        bus.RegWrite  = 1'b1;
        state_d       = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.MemReady) state_d = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ALUSrcB = (state_q == S_EXECI) ? SRCB_IMM : SRCB_RD2;
        if (dec_illegal) begin
          bus.Illegal = 1'b1;
          state_d     = S_FETCH;
        end else begin
          state_d     = S_ALUWB;
        end
      end
      S_ALUWB: begin
        bus.RegWrite = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALUSrcA = SRCA_RD1;
        bus.ImmSrc  = IMM_B;
        branch      = 1'b1;
        bus.Illegal = branch_illegal;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pc_update   = 1'b1;
        state_d     = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase

    bus.ALUControl = dec_control;
    bus.PCWrite    = pc_update | (branch & taken);

    // Reset silences every request and enable, even mid-access.
    if (RST) begin
      bus.PCWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemRead    = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = 2'b00;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b00;
      bus.ImmSrc     = 2'b00;
      bus.ALUControl = ALU_ADD;
      bus.Illegal    = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed cases plus random instructions,
// each scored per instruction against a latency/count reference model.
module tb_multicycle_controller;

  localparam logic [31:0] FETCH_SIG = 32'h0000_004A;

  logic CLK = 1'b0;
  logic RST;
  int   vectors     = 0;
  int   miscompares = 0;
  logic [6:0] op_table [8];

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {14'd0, bus.PCWrite, bus.AdrSrc, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.RegWrite,
            bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.Illegal};
  endfunction

  // MemRead=1, AdrSrc=0, MemWrite=0, ALUSrcB=PC+4, ResultSrc=ALUResult
  function automatic logic [31:0] fetchSignature();
    return {25'd0, bus.MemRead, bus.AdrSrc, bus.MemWrite, bus.ALUSrcB, bus.ResultSrc};
  endfunction

  task automatic tickCycle(input logic ready);
    @(negedge CLK);
    bus.MemReady = ready;
    #1;
  endtask

  // One whole instruction: the cache answers each request after its stall count.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7b5,
                               input logic zero, input logic sign, input int f_stall, input int m_stall);
    bit   is_load, is_store, is_r, is_i, is_br, is_jal, known, exec_bad, br_legal, br_taken, req;
    int   exp_cycles, exp_reg, exp_pc, exp_ill, exp_rd, exp_wr, exec_cycle, stall_now;
    int   n_reg = 0, n_pc = 0, n_ill = 0, n_rd = 0, n_wr = 0, n_ir = 0;
    int   last_reg = -1, waited = 0, access = 0;
    logic [2:0] exp_alu;
    logic [1:0] exp_res, res_at_reg = 2'b11;
    string id;

    is_load  = (op == 7'b0000011);
    is_store = (op == 7'b0100011);
    is_r     = (op == 7'b0110011);
    is_i     = (op == 7'b0010011);
    is_br    = (op == 7'b1100011);
    is_jal   = (op == 7'b1101111);
    known    = is_load | is_store | is_r | is_i | is_br | is_jal;
    exec_bad = (is_r | is_i) && (f3 == 3'd2 || f3 == 3'd3 || (f3 == 3'd5 && f7b5));
`ifdef BRANCH_EXT_EN
    br_legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5);
`else
    br_legal = (f3 == 3'd0);
`endif
    case (f3)
      3'd0:    br_taken = zero;
      3'd1:    br_taken = !zero;
      3'd4:    br_taken = sign;
      default: br_taken = !sign;
    endcase

    if (!known)              exp_cycles = 2;
    else if (is_r || is_i)   exp_cycles = exec_bad ? 3 : 4;
    else if (is_load)        exp_cycles = 5 + m_stall;
    else if (is_store)       exp_cycles = 4 + m_stall;
    else if (is_br)          exp_cycles = 3;
    else                     exp_cycles = 4;
    exp_cycles += f_stall;

    exp_reg    = ((is_r || is_i) && !exec_bad) || is_load || is_jal;
    exp_pc     = 1 + int'(is_jal) + int'(is_br && br_legal && br_taken);
    exp_ill    = int'(!known || exec_bad || (is_br && !br_legal));
    exp_rd     = f_stall + 1 + (is_load ? m_stall + 1 : 0);
    exp_wr     = is_store ? m_stall + 1 : 0;
    exp_res    = is_load ? 2'b01 : 2'b00;
    exec_cycle = (known && !exec_bad) ? f_stall + 2 : -1;
    if (is_r || is_i) exp_alu = (f3 == 3'd0 && is_r && f7b5) ? 3'b010 : f3;
    else if (is_br)   exp_alu = 3'b010;
    else              exp_alu = 3'b000;
    id = $sformatf("op=%b f3=%b f7b5=%0d z=%0d s=%0d", op, f3, f7b5, zero, sign);

    for (int c = 0; c < exp_cycles; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        bus.Op       = op;
        bus.Funct3   = f3;
        bus.Funct7b5 = f7b5;
        bus.Zero     = zero;
        bus.Sign     = sign;
      end
      stall_now = (access == 0) ? f_stall : m_stall;
      req       = bus.MemRead | bus.MemWrite;
      if (req && waited >= stall_now) begin
        bus.MemReady = 1'b1;
        waited       = 0;
        access++;
      end else begin
        bus.MemReady = 1'b0;
        if (req) waited++;
      end
      #1;
      if (c == 0)          checkOutput({"fetch_entry ", id}, fetchSignature(), FETCH_SIG);
      if (c == exec_cycle) checkOutput({"exec_alu ", id}, 32'(bus.ALUControl), 32'(exp_alu));
      n_reg += int'(bus.RegWrite);
      n_pc  += int'(bus.PCWrite);
      n_ill += int'(bus.Illegal);
      n_rd  += int'(bus.MemRead);
      n_wr  += int'(bus.MemWrite);
      n_ir  += int'(bus.IRWrite);
      if (bus.RegWrite) begin
        last_reg   = c;
        res_at_reg = bus.ResultSrc;
      end
    end

    checkOutput({"ir_writes ", id}, n_ir, 1);
    checkOutput({"reg_writes ", id}, n_reg, exp_reg);
    checkOutput({"pc_writes ", id}, n_pc, exp_pc);
    checkOutput({"illegal_pulses ", id}, n_ill, exp_ill);
    checkOutput({"mem_read_cycles ", id}, n_rd, exp_rd);
    checkOutput({"mem_write_cycles ", id}, n_wr, exp_wr);
    if (exp_reg != 0) begin
      checkOutput({"reg_write_cycle ", id}, last_reg, exp_cycles - 1);
      checkOutput({"reg_result_src ", id}, 32'(res_at_reg), 32'(exp_res));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    op_table[0] = 7'b0000011; op_table[1] = 7'b0100011;
    op_table[2] = 7'b0110011; op_table[3] = 7'b0010011;
    op_table[4] = 7'b1100011; op_table[5] = 7'b1101111;
    op_table[6] = 7'b1110011; op_table[7] = 7'b0110111;

    RST = 1'b1;
    bus.MemReady = 1'b0;
    bus.Op = 7'd0; bus.Funct3 = 3'd0; bus.Funct7b5 = 1'b0; bus.Zero = 1'b0; bus.Sign = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #1 checkOutput("reset_outputs_zero", allOutputs(), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1 checkOutput("reset_release_fetch", fetchSignature(), FETCH_SIG);

    $display("[TB] directed cases");
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);  // add
    applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);  // sub
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);  // lw, 3 stall cycles
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);  // beq taken
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);  // beq not taken
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b0, 0, 0);  // bne
    applyStimulus(7'b1110011, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);  // ecall opcode
    applyStimulus(7'b0010011, 3'b101, 1'b1, 1'b0, 1'b0, 1, 0);  // srai
    applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0, 2, 0);  // jal

    // Reset arriving while a store is stalled on the cache.
    @(negedge CLK);
    bus.Op = 7'b0100011; bus.Funct3 = 3'b010; bus.Funct7b5 = 1'b0;
    bus.MemReady = 1'b1;
    #1;
    tickCycle(1'b0);
    tickCycle(1'b0);
    tickCycle(1'b0);
    checkOutput("sw_stalled_memwrite", 32'(bus.MemWrite), 32'd1);
    tickCycle(1'b0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    @(negedge CLK);
    #1 checkOutput("rst_mid_store_outputs", allOutputs(), 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    #1 checkOutput("rst_mid_store_fetch", fetchSignature(), FETCH_SIG);

    $display("[TB] random instructions");
    for (int n = 0; n < 120; n++) begin
      applyStimulus(op_table[$urandom_range(0, 7)], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    @(negedge CLK);
    bus.MemReady = 1'b0;
    #1 checkOutput("final_fetch", fetchSignature(), FETCH_SIG);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
